// File: rtl/push_pkg.sv
// Shared definitions for the push-button conditioner: button indices, per-button
// FSM encoding and the chord detector used to freeze auto-repeat.
package push_pkg;

   localparam int unsigned NUM_BTN    = 5;
   localparam int unsigned BTN_ARRIBA = 0;
   localparam int unsigned BTN_ABAJO  = 1;
   localparam int unsigned BTN_IZQ    = 2;
   localparam int unsigned BTN_DER    = 3;
   localparam int unsigned BTN_CENTRO = 4;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DELAY  = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;
   localparam logic [1:0] ST_HELD   = 2'd3;

   // High when two or more direction buttons are held together.
   function automatic logic is_chord(input logic [BTN_DER:0] lvl);
      return $countones(lvl) > 1;
   endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button: 2-FF synchroniser, consecutive-mismatch counter and stable level,
// with registered one-cycle rise/fall strobes aligned to the cycle after the change.
module debounce_cell #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic Reset,
   input  logic btn_raw,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          stable_q, stable_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d  = btn_raw;
      sync2_d  = sync1_q;
      cnt_d    = '0;
      stable_d = stable_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      // Any cycle where the synchronised input agrees with stable restarts the count.
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            rise_d   = sync2_q;
            fall_d   = ~sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;
   assign rise   = rise_q;
   assign fall   = fall_q;

endmodule

// File: rtl/push_conditioner.sv
// Debounces the five editing buttons and turns them into press pulses plus
// auto-repeat step pulses, with direction priority, chord freeze and enable gating.
module push_conditioner
   import push_pkg::*;
#(
   parameter int unsigned         DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned         REPEAT_DELAY    = 50_000_000,
   parameter int unsigned         REPEAT_PERIOD   = 15_000_000,
   parameter logic [NUM_BTN-1:0]  REPEAT_MASK     = 5'b00011
) (
   input  logic               clk,
   input  logic               Reset,
   input  logic               enable,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_step
);

   localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                      : REPEAT_PERIOD;
   localparam int unsigned TW      = ($clog2(TMR_MAX) < 1) ? 1 : $clog2(TMR_MAX);
   localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);

   logic [NUM_BTN-1:0] stable, rise, fall, win;
   logic [BTN_DER:0]   dir_rise, dir_win;
   logic               chord;

   logic [1:0]         st_q [NUM_BTN];
   logic [1:0]         st_d [NUM_BTN];
   logic [TW-1:0]      tmr_q [NUM_BTN];
   logic [TW-1:0]      tmr_d [NUM_BTN];
   logic [NUM_BTN-1:0] press_q, press_d;
   logic [NUM_BTN-1:0] step_q, step_d;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_cell
      debounce_cell #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
         .clk    (clk),
         .Reset  (Reset),
         .btn_raw(btn_raw[g]),
         .stable (stable[g]),
         .rise   (rise[g]),
         .fall   (fall[g])
      );
   end

   // Lowest set bit wins: arriba outranks abajo outranks izquierda outranks derecha.
   assign dir_rise = rise[BTN_DER:0] & {(BTN_DER + 1){enable}};
   assign dir_win  = dir_rise & (~dir_rise + 1'b1);
   assign win      = {rise[BTN_CENTRO] & enable, dir_win};
   assign chord    = is_chord(stable[BTN_DER:0]);

   always_comb begin
      press_d = '0;
      step_d  = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         st_d[i]  = st_q[i];
         tmr_d[i] = tmr_q[i];
         if (fall[i]) begin
            st_d[i] = ST_IDLE;
         end else if (!enable && stable[i]) begin
            st_d[i] = ST_HELD;
         end else begin
            case (st_q[i])
               ST_IDLE: begin
                  if (rise[i]) begin
                     if (!win[i]) begin
                        st_d[i] = ST_HELD;
                     end else begin
                        press_d[i] = 1'b1;
                        step_d[i]  = 1'b1;
                        if (REPEAT_MASK[i]) begin
                           st_d[i]  = ST_DELAY;
                           tmr_d[i] = DELAY_LOAD;
                        end else begin
                           st_d[i] = ST_HELD;
                        end
                     end
                  end
               end
               ST_DELAY, ST_REPEAT: begin
                  if (!chord) begin
                     if (tmr_q[i] == '0) begin
                        step_d[i] = 1'b1;
                        tmr_d[i]  = PERIOD_LOAD;
                        st_d[i]   = ST_REPEAT;
                     end else begin
                        tmr_d[i] = tmr_q[i] - 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         for (int i = 0; i < NUM_BTN; i++) begin
            st_q[i]  <= ST_IDLE;
            tmr_q[i] <= '0;
         end
         press_q <= '0;
         step_q  <= '0;
      end else begin
         st_q    <= st_d;
         tmr_q   <= tmr_d;
         press_q <= press_d;
         step_q  <= step_d;
      end
   end

   assign btn_level = stable;
   assign btn_press = press_q & {NUM_BTN{enable}};
   assign btn_step  = step_q & {NUM_BTN{enable}};

endmodule

// File: tb/tb_push_conditioner.sv
// Bench for push_conditioner: directed table, hand sequences for repeat/chord/enable/reset,
// then random stimulus, all checked every cycle against a window-based behavioural model.
module tb_push_conditioner;

   localparam int unsigned DC   = 4;
   localparam int unsigned RD   = 20;
   localparam int unsigned RP   = 8;
   localparam logic [4:0]  MASK = 5'b00011;

   logic       clk = 1'b0;
   logic       Reset;
   logic       enable;
   logic [4:0] btn_raw, btn_level, btn_press, btn_step;

   push_conditioner #(
      .DEBOUNCE_CYCLES(DC),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP),
      .REPEAT_MASK    (MASK)
   ) dut (
      .clk      (clk),
      .Reset    (Reset),
      .enable   (enable),
      .btn_raw  (btn_raw),
      .btn_level(btn_level),
      .btn_press(btn_press),
      .btn_step (btn_step)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Model state: raw sample history (index 0 newest), stable levels, per-button mode.
   logic [4:0] hist [$];
   logic [4:0] m_stable, m_rise, m_fall, m_press, m_step;
   int         mode [5];      // 0 idle, 1 repeating, 2 held without repeat
   int         elapsed [5];   // unfrozen cycles since the press

   // Sequence logging
   int mon = 0;
   int seq_k = 0;
   int step_log [$];
   int press_log [$];
   int press_cnt [5];

   typedef struct {
      logic       en;
      logic [4:0] raw;
      logic [4:0] level;
      logic [4:0] press;
      logic [4:0] step;
   } vec_t;
   vec_t tbl [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_edge(input logic rst, input logic en, input logic [4:0] raw);
      logic       chord;
      logic       all_diff;
      logic [4:0] nxt;
      int         winner;
      if (rst) begin
         hist.delete();
         for (int j = 0; j < DC + 2; j++) hist.push_back(5'b0);
         m_stable = '0; m_rise = '0; m_fall = '0; m_press = '0; m_step = '0;
         for (int b = 0; b < 5; b++) begin
            mode[b] = 0;
            elapsed[b] = 0;
         end
         return;
      end
      chord  = $countones(m_stable[3:0]) >= 2;
      winner = -1;
      for (int b = 0; b < 4; b++) if (winner < 0 && en && m_rise[b]) winner = b;
      m_press = '0;
      m_step  = '0;
      for (int b = 0; b < 5; b++) begin
         if (m_fall[b]) begin
            mode[b] = 0;
         end else if (!en && m_stable[b]) begin
            mode[b] = 2;
         end else if (m_rise[b]) begin
            if (b < 4 && b != winner) begin
               mode[b] = 2;
            end else begin
               m_press[b] = 1'b1;
               m_step[b]  = 1'b1;
               mode[b]    = MASK[b] ? 1 : 2;
               elapsed[b] = 0;
            end
         end else if (mode[b] == 1 && !chord) begin
            elapsed[b]++;
            if (elapsed[b] == RD || (elapsed[b] > RD && (elapsed[b] - RD) % RP == 0))
               m_step[b] = 1'b1;
         end
      end
      // Synchronised value seen now is the raw value from two edges ago; the level flips
      // once the last DC synchronised samples all disagree with it.
      hist.push_front(raw);
      void'(hist.pop_back());
      nxt = m_stable;
      for (int b = 0; b < 5; b++) begin
         all_diff = 1'b1;
         for (int j = 2; j < DC + 2; j++) if (hist[j][b] == m_stable[b]) all_diff = 1'b0;
         if (all_diff) nxt[b] = ~m_stable[b];
      end
      m_rise   = nxt & ~m_stable;
      m_fall   = ~nxt & m_stable;
      m_stable = nxt;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge(Reset, enable, btn_raw);
      cyc++;
      @(negedge clk);
      check("model_level", btn_level, m_stable);
      check("model_press", btn_press, m_press & {5{enable}});
      check("model_step", btn_step, m_step & {5{enable}});
      if (btn_step[mon]) step_log.push_back(seq_k);
      if (btn_press[mon]) press_log.push_back(seq_k);
      for (int b = 0; b < 5; b++) if (btn_press[b]) press_cnt[b]++;
      seq_k++;
   endtask

   task automatic start_seq(input int b);
      mon   = b;
      seq_k = 0;
      step_log.delete();
      press_log.delete();
      for (int i = 0; i < 5; i++) press_cnt[i] = 0;
   endtask

   task automatic idle(input int n);
      btn_raw = '0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_list(input string name, input int act[$], input int exp[$]);
      check({name, "_count"}, act.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         check({name, "_at"}, (i < act.size()) ? act[i] : -1, exp[i]);
   endtask

   function automatic void add(input logic en, input logic [4:0] raw, input logic [4:0] lvl,
                               input logic [4:0] prs, input logic [4:0] stp);
      vec_t v;
      v.en = en; v.raw = raw; v.level = lvl; v.press = prs; v.step = stp;
      tbl.push_back(v);
   endfunction

   initial begin
      int         exp_q [$];
      logic [4:0] held;

      Reset = 1'b1; enable = 1'b1; btn_raw = '0;
      tick(); tick();
      check("reset_state", {btn_level, btn_press, btn_step}, 15'h0);
      Reset = 1'b0;
      idle(3);

      // Clean press on arriba, then release: one pulse, level follows after debounce.
      add(1, 5'h01, 5'h00, 5'h00, 5'h00); add(1, 5'h01, 5'h00, 5'h00, 5'h00);
      add(1, 5'h01, 5'h00, 5'h00, 5'h00); add(1, 5'h01, 5'h00, 5'h00, 5'h00);
      add(1, 5'h01, 5'h00, 5'h00, 5'h00); add(1, 5'h01, 5'h01, 5'h00, 5'h00);
      add(1, 5'h01, 5'h01, 5'h01, 5'h01); add(1, 5'h01, 5'h01, 5'h00, 5'h00);
      add(1, 5'h01, 5'h01, 5'h00, 5'h00); add(1, 5'h01, 5'h01, 5'h00, 5'h00);
      add(1, 5'h01, 5'h01, 5'h00, 5'h00); add(1, 5'h00, 5'h01, 5'h00, 5'h00);
      add(1, 5'h00, 5'h01, 5'h00, 5'h00); add(1, 5'h00, 5'h01, 5'h00, 5'h00);
      add(1, 5'h00, 5'h01, 5'h00, 5'h00); add(1, 5'h00, 5'h01, 5'h00, 5'h00);
      add(1, 5'h00, 5'h00, 5'h00, 5'h00); add(1, 5'h00, 5'h00, 5'h00, 5'h00);
      add(1, 5'h00, 5'h00, 5'h00, 5'h00);
      start_seq(0);
      for (int i = 0; i < tbl.size(); i++) begin
         enable  = tbl[i].en;
         btn_raw = tbl[i].raw;
         tick();
         check("tbl_level", btn_level, tbl[i].level);
         check("tbl_press", btn_press, tbl[i].press);
         check("tbl_step", btn_step, tbl[i].step);
      end
      idle(4);

      // Bounce on abajo, then a steady hold.
      start_seq(1);
      for (int k = 0; k < 40; k++) begin
         btn_raw[1] = (k < 12) ? ((k % 4) < 2) : (k < 30);
         tick();
      end
      exp_q = '{18};
      check_list("bounce_press", press_log, exp_q);
      idle(4);

      // Auto-repeat on arriba.
      start_seq(0);
      for (int k = 0; k < 80; k++) begin
         btn_raw[0] = (k < 56);
         tick();
      end
      exp_q = '{6, 26, 34, 42, 50, 58};
      check_list("repeat_step", step_log, exp_q);
      exp_q = '{6};
      check_list("repeat_press", press_log, exp_q);
      idle(4);

      // izquierda has repeat disabled.
      start_seq(2);
      for (int k = 0; k < 75; k++) begin
         btn_raw[2] = (k < 60);
         tick();
      end
      exp_q = '{6};
      check_list("masked_step", step_log, exp_q);
      idle(4);

      // Simultaneous abajo+derecha, then arriba joins briefly; repeats resume after the chord.
      start_seq(1);
      for (int k = 0; k < 75; k++) begin
         btn_raw[1] = (k < 64);
         btn_raw[3] = (k < 30);
         btn_raw[0] = (k >= 10 && k < 20);
         tick();
      end
      exp_q = '{6, 55, 63};
      check_list("chord_step", step_log, exp_q);
      check("chord_loser_press", press_cnt[3], 0);
      check("chord_late_press", press_cnt[0], 1);
      idle(4);

      // Held while disabled: stale until released and pressed again.
      start_seq(0);
      for (int k = 0; k < 60; k++) begin
         enable     = (k >= 15);
         btn_raw[0] = (k < 30) || (k >= 40 && k < 50);
         tick();
         if (k == 10) check("disabled_level", btn_level[0], 1'b1);
      end
      exp_q = '{46};
      check_list("enable_press", press_log, exp_q);
      idle(4);

      // Reset while arriba is held.
      start_seq(0);
      for (int k = 0; k < 50; k++) begin
         btn_raw[0] = (k < 40);
         Reset      = (k == 20);
         tick();
         if (k == 20) check("midreset_outputs", {btn_level, btn_press, btn_step}, 15'h0);
      end
      Reset = 1'b0;
      exp_q = '{6, 27};
      check_list("reset_press", press_log, exp_q);
      idle(4);

      // Random stimulus against the model.
      held = '0;
      for (int k = 0; k < 3000; k++) begin
         for (int b = 0; b < 5; b++) if ($urandom_range(0, 23) == 0) held[b] = ~held[b];
         btn_raw = held;
         if ($urandom_range(0, 29) == 0) btn_raw = held ^ (5'b1 << $urandom_range(0, 4));
         if ($urandom_range(0, 199) == 0) enable = ~enable;
         Reset = ($urandom_range(0, 599) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
